// File: rtl/mem_ctrl.sv
// Memory controller between the CPU datapath bus and a handshaking RAM, with MAR/MDR and ack timeout.
// Define MEM_CTRL_MMIO_EN to map keyboard/display registers at xFE00-xFFFF; otherwise every address goes to RAM.
module mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        arst_n,
    inout  wire  [15:0] bus,
    input  logic        mem_ld_mar,
    input  logic        mem_ld_mdr,
    input  logic        mem_gate_mdr,
    input  logic        mem_mio_en,
    input  logic        mem_rw,
    output logic        mem_rdy,
    output logic        ram_req,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic        ram_ack,
    input  logic [15:0] ram_rdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_pop,
    input  logic        disp_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    output logic        err
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RAM_WAIT = 2'd1;
    localparam logic [1:0] DONE     = 2'd2;
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] mar_q, mar_d, mdr_q, mdr_d, hold_q, hold_d;
    logic [15:0] ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d;
    logic [7:0]  cnt_q, cnt_d, disp_data_q, disp_data_d;
    logic        rw_q, rw_d, err_q, err_d, mem_rdy_q, mem_rdy_d;
    logic        ram_req_q, ram_req_d, ram_we_q, ram_we_d;
    logic        kbd_pop_q, kbd_pop_d, disp_valid_q, disp_valid_d;
    logic        is_mmio_s, kbd_rd_s, ddr_wr_s;
    logic [15:0] mmio_rdata_s;

    assign bus = mem_gate_mdr ? mdr_q : 16'hzzzz;

`ifdef MEM_CTRL_MMIO_EN
    // Device register decode for the top 512 words of the address space.
    always_comb begin
        is_mmio_s    = (mar_q[15:9] == 7'h7F);
        mmio_rdata_s = 16'h0000;
        kbd_rd_s     = 1'b0;
        ddr_wr_s     = 1'b0;
        case (mar_q)
            16'hFE00: mmio_rdata_s = {kbd_valid, 15'h0000};
            16'hFE02: begin
                mmio_rdata_s = {8'h00, kbd_data};
                kbd_rd_s     = 1'b1;
            end
            16'hFE04: mmio_rdata_s = {disp_ready, 15'h0000};
            16'hFE06: ddr_wr_s     = 1'b1;
            default:  mmio_rdata_s = 16'h0000;
        endcase
    end
`else
    logic unused_mmio_s;
    assign unused_mmio_s = ^{kbd_valid, kbd_data, disp_ready};

    // Without device registers every access is a RAM access.
    always_comb begin
        is_mmio_s    = 1'b0;
        mmio_rdata_s = 16'h0000;
        kbd_rd_s     = 1'b0;
        ddr_wr_s     = 1'b0;
    end
`endif

    // Next-state, register-load and output computation.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        rw_d         = rw_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        kbd_pop_d    = 1'b0;
        disp_valid_d = 1'b0;
        disp_data_d  = disp_data_q;

        if (mem_ld_mar) begin
            mar_d = bus;
        end else begin
            mar_d = mar_q;
        end
        if (mem_ld_mdr && !mem_mio_en) begin
            mdr_d = bus;
        end else begin
            mdr_d = mdr_q;
        end

        case (state_q)
            IDLE: begin
                if (mem_mio_en) begin
                    rw_d = mem_rw;
                    if (is_mmio_s) begin
                        state_d = DONE;
                        if (mem_rw) begin
                            disp_valid_d = ddr_wr_s;
                            if (ddr_wr_s) begin
                                disp_data_d = mdr_q[7:0];
                            end else begin
                                disp_data_d = disp_data_q;
                            end
                        end else begin
                            hold_d    = mmio_rdata_s;
                            kbd_pop_d = kbd_rd_s;
                        end
                    end else begin
                        state_d     = RAM_WAIT;
                        cnt_d       = 8'd0;
                        ram_addr_d  = mar_q;
                        ram_wdata_d = mdr_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RAM_WAIT: begin
                if (ram_ack) begin
                    hold_d  = ram_rdata;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    // A dead RAM completes with zero data and leaves a sticky error behind.
                    hold_d  = 16'h0000;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (mem_ld_mdr && !rw_q) begin
                    mdr_d = hold_q;
                end else begin
                    mdr_d = mdr_q;
                end
            end
            default: state_d = IDLE;
        endcase

        ram_req_d = (state_d == RAM_WAIT);
        ram_we_d  = (state_d == RAM_WAIT) && rw_d;
        mem_rdy_d = (state_d == DONE);
    end

    // State and output registers, cleared immediately by the async reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            mar_q        <= 16'h0000;
            mdr_q        <= 16'h0000;
            hold_q       <= 16'h0000;
            rw_q         <= 1'b0;
            cnt_q        <= 8'd0;
            err_q        <= 1'b0;
            ram_addr_q   <= 16'h0000;
            ram_wdata_q  <= 16'h0000;
            ram_req_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            mem_rdy_q    <= 1'b0;
            kbd_pop_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            mar_q        <= mar_d;
            mdr_q        <= mdr_d;
            hold_q       <= hold_d;
            rw_q         <= rw_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_req_q    <= ram_req_d;
            ram_we_q     <= ram_we_d;
            mem_rdy_q    <= mem_rdy_d;
            kbd_pop_q    <= kbd_pop_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
        end
    end

    assign mem_rdy    = mem_rdy_q;
    assign ram_req    = ram_req_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign kbd_pop    = kbd_pop_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign err        = err_q;

endmodule
